// File: rtl/bf_pkg.sv
// Shared types and helpers for the delay-and-sum beamformer.
package bf_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAST,
        WRITE,
        FIN
    } bf_state_e;

    // Widest packed input word the slice helper accepts
    localparam int unsigned MAX_BUS_W = 1024;

    // Accumulator width: sample width plus log2 of the channel count
    function automatic int acc_width(input int num_ch, input int sample_w);
        return sample_w + $clog2(num_ch);
    endfunction

    // Extract signed slice idx of width w from a packed word and sign-extend to 64 bits
    function automatic logic signed [63:0] slice_sext(input logic [MAX_BUS_W-1:0] word,
                                                      input int                   idx,
                                                      input int                   w);
        logic [63:0] lo;
        lo = 64'(word >> (idx * w));
        return $signed(lo << (64 - w)) >>> (64 - w);
    endfunction

endpackage

// File: rtl/param_das_beamformer_if.sv
// Control and BRAM bus bundle for the delay-and-sum beamformer.
interface param_das_beamformer_if
    import bf_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 11,
    parameter int DLY_W    = 8
);
    localparam int ACC_W = acc_width(NUM_CH, SAMPLE_W);
    localparam int SH_W  = $clog2(NUM_CH) + 1;

    // Frame control
    logic                           start;
    logic [ADDR_W:0]                num_samples;
    logic [NUM_CH*DLY_W-1:0]        delays;
    logic [SH_W-1:0]                shift;
    logic                           busy;
    logic                           done;

    // Input BRAM read port
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_addr;
    logic [NUM_CH*SAMPLE_W-1:0]     rd_data;

    // Output BRAM write port
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_addr;
    logic signed [ACC_W-1:0]        wr_data;

    // Host / memory side
    modport master (
        output start, num_samples, delays, shift, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    // Beamformer side
    modport slave (
        input  start, num_samples, delays, shift, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/bf_delay_addr_gen.sv
// Read address and zero-slot generation for one (n, c) read slot.
module bf_delay_addr_gen
    import bf_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 11,
    parameter int DLY_W  = 8
) (
    input  logic [ADDR_W:0]              n_i,
    input  logic [$clog2(NUM_CH)-1:0]    c_i,
    input  logic [NUM_CH*DLY_W-1:0]      delays_i,
    output logic [ADDR_W-1:0]            addr_o,
    output logic                         zero_o
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int NW    = ADDR_W + 1;
    localparam int CMP_W = ((NW > DLY_W) ? NW : DLY_W) + 1;

    logic [DLY_W-1:0] dly;

    // Select the channel delay; a slot whose source index would be negative reads nothing
    always_comb begin
        dly = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c_i == CH_W'(i)) begin
                dly = delays_i[i*DLY_W +: DLY_W];
            end
        end
        zero_o = (CMP_W'(n_i) < CMP_W'(dly));
        // Only meaningful when zero_o is low, so dly <= n and the difference fits
        addr_o = ADDR_W'(n_i - NW'(dly));
    end

endmodule

// File: rtl/param_das_beamformer.sv
// Delay-and-sum beamformer sequencer: reads NUM_CH delayed samples per output,
// sums them, applies an arithmetic right shift and writes one beam sample.
module param_das_beamformer
    import bf_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 11,
    parameter int DLY_W    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    param_das_beamformer_if.slave   bf_if
);
    localparam int ACC_W = acc_width(NUM_CH, SAMPLE_W);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int SH_W  = $clog2(NUM_CH) + 1;
    localparam int NW    = ADDR_W + 1;

    bf_state_e                  state_q, state_d;
    logic [NW-1:0]              n_q, n_d;
    logic [NW-1:0]              num_q, num_d;
    logic [CH_W-1:0]            c_q, c_d;
    logic [CH_W-1:0]            pch_q, pch_d;
    logic                       zero_q, zero_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [NUM_CH*DLY_W-1:0]    dly_q, dly_d;
    logic [SH_W-1:0]            shift_q, shift_d;

    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic signed [ACC_W-1:0]    wr_data_q, wr_data_d;

    logic [MAX_BUS_W-1:0]       rd_word;
    logic signed [ACC_W-1:0]    term;
    logic [ADDR_W-1:0]          gen_addr;
    logic                       gen_zero;

    assign rd_word = MAX_BUS_W'(bf_if.rd_data);

    // Address/zero flag for the slot the FSM is about to enter
    bf_delay_addr_gen #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DLY_W  (DLY_W)
    ) u_addr_gen (
        .n_i      (n_d),
        .c_i      (c_d),
        .delays_i (dly_d),
        .addr_o   (gen_addr),
        .zero_o   (gen_zero)
    );

    // Contribution of the slot read one cycle ago (data arrives with 1-cycle BRAM latency)
    always_comb begin
        term = '0;
        if (!zero_q) begin
            term = ACC_W'(slice_sext(rd_word, int'(pch_q), SAMPLE_W));
        end
    end

    // Next state, counters, accumulator and write port
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        num_d     = num_q;
        c_d       = c_q;
        acc_d     = acc_q;
        dly_d     = dly_q;
        shift_d   = shift_q;
        pch_d     = c_q;
        zero_d    = ~rd_en_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (bf_if.start) begin
                    num_d   = bf_if.num_samples;
                    dly_d   = bf_if.delays;
                    shift_d = bf_if.shift;
                    n_d     = '0;
                    c_d     = '0;
                    acc_d   = '0;
                    state_d = (bf_if.num_samples == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (c_q != '0) begin
                    acc_d = acc_q + term;
                end
                if (c_q == CH_W'(NUM_CH - 1)) begin
                    state_d = LAST;
                end else begin
                    c_d = c_q + CH_W'(1);
                end
            end
            LAST: begin
                acc_d     = acc_q + term;
                wr_en_d   = 1'b1;
                wr_addr_d = n_q[ADDR_W-1:0];
                wr_data_d = acc_d >>> shift_q;
                state_d   = WRITE;
            end
            WRITE: begin
                acc_d = '0;
                if ((n_q + NW'(1)) == num_q) begin
                    state_d = FIN;
                end else begin
                    n_d     = n_q + NW'(1);
                    c_d     = '0;
                    state_d = READ;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read port and status flags follow the state being entered
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        if ((state_d == READ) && !gen_zero) begin
            rd_en_d   = 1'b1;
            rd_addr_d = gen_addr;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // State and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            n_q       <= '0;
            num_q     <= '0;
            c_q       <= '0;
            pch_q     <= '0;
            zero_q    <= 1'b1;
            acc_q     <= '0;
            dly_q     <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            num_q     <= num_d;
            c_q       <= c_d;
            pch_q     <= pch_d;
            zero_q    <= zero_d;
            acc_q     <= acc_d;
            dly_q     <= dly_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bf_if.busy    = busy_q;
    assign bf_if.done    = done_q;
    assign bf_if.rd_en   = rd_en_q;
    assign bf_if.rd_addr = rd_addr_q;
    assign bf_if.wr_en   = wr_en_q;
    assign bf_if.wr_addr = wr_addr_q;
    assign bf_if.wr_data = wr_data_q;

endmodule

// File: tb/tb_param_das_beamformer.sv
// Scoreboard bench for param_das_beamformer with a behavioural input BRAM.
module tb_param_das_beamformer;
    import bf_pkg::*;

    localparam int NC    = 3;
    localparam int SW    = 12;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int SH_W  = $clog2(NC) + 1;
    localparam int PER   = NC + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    param_das_beamformer_if #(.NUM_CH(NC), .SAMPLE_W(SW), .ADDR_W(AW), .DLY_W(DW)) bus ();

    param_das_beamformer #(.NUM_CH(NC), .SAMPLE_W(SW), .ADDR_W(AW), .DLY_W(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bf_if  (bus)
    );

    typedef struct {
        int     addr;
        longint data;
    } wr_exp_t;

    wr_exp_t             sb_q[$];
    logic signed [SW-1:0] xm [0:(1<<AW)-1][0:NC-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    int edge_cnt   = 0;
    int start_base = 0;
    bit frame_on   = 1'b0;
    int cur_n      = 0;
    int cur_d[NC];
    int first_wr   = -1;
    int first_rd   = -1;
    int done_cyc   = -1;
    int done_cnt   = 0;
    int wr_cnt     = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Input BRAM: one-cycle read latency
    always @(posedge clk) begin
        if (bus.rd_en) begin
            for (int c = 0; c < NC; c++) begin
                bus.rd_data[c*SW +: SW] <= xm[bus.rd_addr][c];
            end
        end
    end

    // Monitor: read-slot model, write scoreboard, done tracking
    always @(negedge clk) begin
        int      cyc;
        int      p;
        int      nn;
        bit      exp_rd;
        wr_exp_t e;
        cyc = edge_cnt - start_base;
        if (rst_n) begin
            if (frame_on && cyc >= 1 && cyc <= cur_n * PER) begin
                p      = (cyc - 1) % PER;
                nn     = (cyc - 1) / PER;
                exp_rd = (p < NC) && (nn >= cur_d[p]);
                check("rd_en", longint'(bus.rd_en), longint'(exp_rd));
                if (exp_rd && bus.rd_en)
                    check("rd_addr", longint'(bus.rd_addr), longint'(nn - cur_d[p]));
                if (bus.rd_en && first_rd < 0) first_rd = cyc;
            end else if (bus.rd_en) begin
                check("rd_stray", longint'(bus.rd_en), 0);
            end
            if (bus.wr_en) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                check("rd_wr_excl", longint'(bus.rd_en), 0);
                if (sb_q.size() == 0) begin
                    check("wr_unexpected", longint'(bus.wr_en), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", longint'(bus.wr_addr), longint'(e.addr));
                    check("wr_data", longint'(bus.wr_data), e.data);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic logic [NC*DW-1:0] mkd(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    // Fill the BRAM for a frame and push the expected beam samples
    task automatic load_frame(input int n, input logic [NC*DW-1:0] dv, input int sh, input int pat);
        longint  s;
        wr_exp_t e;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < NC; c++) begin
                if (pat == 0)      xm[k][c] = SW'(k + 1);
                else if (pat == 1) xm[k][c] = SW'(-2048);
                else               xm[k][c] = SW'($urandom());
            end
        end
        for (int c = 0; c < NC; c++) cur_d[c] = int'(dv[c*DW +: DW]);
        for (int nn = 0; nn < n; nn++) begin
            s = 0;
            for (int c = 0; c < NC; c++) begin
                if (nn >= cur_d[c]) s += longint'(xm[nn - cur_d[c]][c]);
            end
            e.addr = nn;
            e.data = s >>> sh;
            sb_q.push_back(e);
        end
    endtask

    task automatic start_frame(input int n, input logic [NC*DW-1:0] dv, input int sh, input int pat);
        load_frame(n, dv, sh, pat);
        @(negedge clk); #1;
        bus.num_samples = (AW+1)'(n);
        bus.delays      = dv;
        bus.shift       = SH_W'(sh);
        bus.start       = 1'b1;
        start_base      = edge_cnt;
        cur_n           = n;
        first_wr        = -1;
        first_rd        = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        wr_cnt          = 0;
        frame_on        = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_frame(input int spur, input bit timing);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (edge_cnt - start_base == spur) begin
                bus.start       = 1'b1;
                bus.delays      = mkd(2, 2, 2);
                bus.num_samples = (AW+1)'(9);
            end else begin
                bus.start = 1'b0;
            end
            if (done_cnt > 0) break;
        end
        check("done_seen", longint'(done_cnt), 1);
        repeat (4) @(negedge clk);
        #1;
        bus.start = 1'b0;
        check("done_once", longint'(done_cnt), 1);
        check("busy_after", longint'(bus.busy), 0);
        check("sb_drained", longint'(sb_q.size()), 0);
        check("wr_count", longint'(wr_cnt), longint'(cur_n));
        if (timing) begin
            check("done_cycle", longint'(done_cyc), longint'(cur_n * PER + 1));
            if (cur_n > 0) check("first_wr_cycle", longint'(first_wr), longint'(PER));
            if (cur_n > 0 && cur_d[0] == 0) check("first_rd_cycle", longint'(first_rd), 1);
        end
        frame_on = 1'b0;
        sb_q.delete();
    endtask

    task automatic run_frame(input int n, input logic [NC*DW-1:0] dv, input int sh,
                             input int pat, input int spur);
        start_frame(n, dv, sh, pat);
        finish_frame(spur, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.delays      = '0;
        bus.shift       = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",    longint'(bus.busy),    0);
        check("rst_done",    longint'(bus.done),    0);
        check("rst_rd_en",   longint'(bus.rd_en),   0);
        check("rst_wr_en",   longint'(bus.wr_en),   0);
        check("rst_rd_addr", longint'(bus.rd_addr), 0);
        check("rst_wr_addr", longint'(bus.wr_addr), 0);
        check("rst_wr_data", longint'(bus.wr_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Baseline ramp, delays (0,1,2) -> 1,3,6,9
        run_frame(4, mkd(0, 1, 2), 0, 0, -1);
        // Negative extreme, with and without shift
        run_frame(2, mkd(0, 0, 0), 0, 1, -1);
        run_frame(2, mkd(0, 0, 0), 1, 1, -1);
        // Delay beyond frame length -> channel 2 silent
        run_frame(4, mkd(0, 0, 200), 0, 0, -1);
        // Empty frame
        run_frame(0, mkd(0, 1, 2), 0, 0, -1);
        // Start pulse while busy is ignored
        run_frame(4, mkd(0, 1, 2), 0, 0, 3);

        // Reset in the middle of a baseline frame
        start_frame(4, mkd(0, 1, 2), 0, 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (edge_cnt - start_base == 7) break;
        end
        frame_on = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_busy",    longint'(bus.busy),    0);
        check("mid_rst_rd_en",   longint'(bus.rd_en),   0);
        check("mid_rst_wr_en",   longint'(bus.wr_en),   0);
        check("mid_rst_done",    longint'(bus.done),    0);
        check("mid_rst_wr_data", longint'(bus.wr_data), 0);
        check("mid_rst_writes",  longint'(wr_cnt),      1);
        check("mid_rst_sb_left", longint'(sb_q.size()), 3);
        sb_q.delete();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("no_resume_writes", longint'(wr_cnt),   1);
        check("no_resume_busy",   longint'(bus.busy), 0);
        run_frame(4, mkd(0, 1, 2), 0, 0, -1);

        // Randomised frames
        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(1, 8)),
                      mkd(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 6))),
                      int'($urandom_range(0, 3)), 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_das_beamformer.md
Name: param_das_beamformer

Overview:
Parametrised delay-and-sum beamformer sequencer. It reads packed multi-channel samples from an external input BRAM and applies an independent integer delay to each channel. The delayed samples are summed, with optional arithmetic scaling, and each beam sample is written to an external output BRAM. It is the next generation of the fixed three-slice BRAM beamformer wrapper and generalises channel count, sample width, depth and per-channel delay.

Parameters:
NUM_CH, 3, channels packed per input word (>=2)
SAMPLE_W, 12, signed sample width per channel
ADDR_W, 11, input/output BRAM address width
DLY_W, 8, per-channel delay width in samples
ACC_W, SAMPLE_W+$clog2(NUM_CH), accumulator/output width (localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a frame; ignored while busy
num_samples  in  ADDR_W+1  frame length N; latched at start
delays  in  NUM_CH*DLY_W  per-channel delay d_c, channel c at bits [c*DLY_W +: DLY_W]; latched at start
shift  in  $clog2(NUM_CH)+1  arithmetic right shift applied to sum; latched at start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last write
rd_en  out  1  input BRAM read enable
rd_addr  out  ADDR_W  input BRAM address
rd_data  in  NUM_CH*SAMPLE_W  input BRAM data, 1-cycle latency, channel c at [c*SAMPLE_W +: SAMPLE_W]
wr_en  out  1  output BRAM write strobe
wr_addr  out  ADDR_W  output address = n
wr_data  out  ACC_W  beam sample, signed

Behaviour:
- Function: y[n] = (sum over c of x_c[n-d_c]) >>> shift, for n = 0..N-1. The term x_c[k] is 0 when k<0.
- Reset: busy, done, rd_en and wr_en are 0. rd_addr, wr_addr and wr_data are 0. FSM is in IDLE and the accumulator is cleared.
- FSM states: IDLE, READ, LAST, WRITE, FIN.
- IDLE -> READ on start when N>0. Frame counter n=0, channel counter c=0, acc=0.
- IDLE -> FIN on start when N==0. No reads and no writes occur.
- READ, one cycle per channel c = 0..NUM_CH-1:
  - if n>=d_c: rd_en=1, rd_addr=n-d_c.
  - otherwise: rd_en=0 and a registered zero flag is set for that slot.
  - From c>=1 onward, each READ cycle also accumulates the slice of the previous channel (c-1) from rd_data, sign-extended to ACC_W, or 0 if its zero flag was set.
  - After c=NUM_CH-1 the FSM goes to LAST.
- LAST: accumulates the slice of channel NUM_CH-1. rd_en=0. Then goes to WRITE.
- WRITE: wr_en=1, wr_addr=n, wr_data=acc>>>shift (arithmetic). Then clears acc.
  - if n==N-1: go to FIN.
  - otherwise: n++, c=0, go to READ.
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Throughput: NUM_CH+2 cycles per output sample.
- Latency: start sampled at edge 0 gives first rd_en in cycle 1, first wr_en in cycle NUM_CH+2, and done in cycle N*(NUM_CH+2)+1.
- Arithmetic: ACC_W has enough headroom that the sum never overflows, so no saturation is needed. A shift value >= ACC_W yields 0 for non-negative sums and -1 for negative sums.
- Boundaries:
  - d_c >= N: that channel contributes 0 for the whole frame and issues no reads for it.
  - d_c = 0: that channel is read at address n.
  - Reads never address beyond N-1.
- start while busy: ignored. Configuration changes while busy: no effect on the current frame.
- rst_n asserted mid-frame: outputs drop immediately to their reset values. No further writes occur, and a partial frame is not resumed.
- wr_en and rd_en are never high in the same cycle.

Decomposition:
- Package bf_pkg holds:
  - the FSM state enum (IDLE, READ, LAST, WRITE, FIN);
  - a function for slice extraction and sign extension;
  - the ACC_W computation helper.
- One natural sub-module is bf_delay_addr_gen: combinational/registered generation of rd_addr and the zero flag from n, c and the delays vector. The accumulator and FSM stay in the top level.

Test Plan:
- Baseline: NUM_CH=3, SAMPLE_W=12, x_c[k]=k+1 for all c, delays=(0,1,2), N=4, shift=0 -> writes y=[1,3,6,9] at addresses 0..3; first wr_en at cycle 5; done at cycle 21.
- Negative extreme: all samples -2048, delays=0, N=2, shift=0 -> wr_data=-6144 at both addresses. With shift=1 -> -3072.
- Out-of-range delay: delays=(0,0,200), N=4, x=k+1 -> y=[2,4,6,8]; rd_addr is never issued for channel 2.
- Empty frame: N=0 and start -> done pulse at cycle 1; wr_en and rd_en stay 0.
- Mid-frame reset: assert rst_n=0 at cycle 7 of the baseline frame -> busy, rd_en and wr_en go 0 asynchronously; only y[0] was written. A new start after release runs the full frame correctly.
- Start while busy: pulse start at cycle 3 with different delays -> ignored; results match the baseline; done fires exactly once.
